// File: rtl/round_sequencer_if.sv
// Round sequencer bus: the four debounced/enable inputs and the six registered status outputs.
// The sequencer itself uses the slave view; the driving side uses the master view.
interface round_sequencer_if;
    logic        tick;
    logic        ms_tick;
    logic        go;
    logic        press;
    logic [15:0] count;
    logic        start;
    logic [1:0]  state;
    logic [15:0] react_time;
    logic        false_start;
    logic        done;

    modport slave (
        input  tick, ms_tick, go, press,
        output count, start, state, react_time, false_start, done
    );

    modport master (
        output tick, ms_tick, go, press,
        input  count, start, state, react_time, false_start, done
    );
endinterface

// File: rtl/round_sequencer.sv
// Reaction-game round sequencer: IDLE -> COUNTDOWN -> PLAY -> RESULT, timing the player's press.
// Optional feature: define ROUND_TIMEOUT_EN to end PLAY once react_time reaches TIMEOUT_MS.
module round_sequencer #(
    parameter logic [15:0] COUNT_INIT = 16'd5,
    parameter logic [15:0] TIMEOUT_MS = 16'd5000
) (
    input  logic              clock,
    input  logic              reset,
    round_sequencer_if.slave  bus
);

`ifdef ROUND_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        RESULT    = 2'd3
    } state_t;

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        start_reg;
    logic [15:0] react_reg;
    logic        false_start_reg;
    logic        done_reg;

    // 17-bit increment so a saturated react_time can never alias a timeout value.
    logic [16:0] react_inc;
    logic        timeout_hit;

    assign react_inc   = {1'b0, react_reg} + 17'd1;
    assign timeout_hit = TIMEOUT_ON && (react_inc == {1'b0, TIMEOUT_MS});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            count_reg       <= COUNT_INIT;
            start_reg       <= 1'b0;
            react_reg       <= 16'd0;
            false_start_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    count_reg <= COUNT_INIT;
                    if (bus.go) begin
                        state_reg <= COUNTDOWN;
                    end
                end
                COUNTDOWN: begin
                    if (bus.press) begin
                        false_start_reg <= 1'b1;
                        react_reg       <= 16'hFFFF;
                        state_reg       <= RESULT;
                        done_reg        <= 1'b1;
                    end else if (count_reg == 16'd0) begin
                        state_reg <= PLAY;
                        start_reg <= 1'b1;
                        react_reg <= 16'd0;
                    end else if (bus.tick) begin
                        count_reg <= count_reg - 16'd1;
                        if (count_reg == 16'd1) begin
                            state_reg <= PLAY;
                            start_reg <= 1'b1;
                            react_reg <= 16'd0;
                        end
                    end
                end
                PLAY: begin
                    // A press wins over a coincident ms_tick, freezing the measured time.
                    if (bus.press) begin
                        state_reg <= RESULT;
                        start_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (bus.ms_tick) begin
                        if (timeout_hit) begin
                            state_reg       <= RESULT;
                            start_reg       <= 1'b0;
                            done_reg        <= 1'b1;
                            react_reg       <= 16'hFFFF;
                            false_start_reg <= 1'b0;
                        end else if (react_reg != 16'hFFFF) begin
                            react_reg <= react_inc[15:0];
                        end
                    end
                end
                RESULT: begin
                    if (bus.go) begin
                        state_reg       <= COUNTDOWN;
                        count_reg       <= COUNT_INIT;
                        react_reg       <= 16'd0;
                        false_start_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.count       = count_reg;
    assign bus.start       = start_reg;
    assign bus.state       = state_reg;
    assign bus.react_time  = react_reg;
    assign bus.false_start = false_start_reg;
    assign bus.done        = done_reg;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: an abstract round model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_round_sequencer;

    localparam logic [15:0] INIT = 16'd5;
    localparam logic [15:0] TMO  = 16'd10;

    logic clock;
    logic reset;
    round_sequencer_if bus ();

    round_sequencer #(.COUNT_INIT(INIT), .TIMEOUT_MS(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Model: phase number, ticks consumed, ms elapsed (unbounded), flags.
    int m_ph, m_ticks, m_ms;
    bit m_fs, m_to, m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_reset();
        m_ph = 0; m_ticks = 0; m_ms = 0; m_fs = 0; m_to = 0; m_done = 0;
    endtask

    function automatic int remaining();
        return int'(INIT) - m_ticks;
    endfunction

    task automatic model_step(input bit g, input bit t, input bit m, input bit p);
        m_done = 0;
        case (m_ph)
            0: if (g) begin m_ph = 1; m_ticks = 0; end
            1: begin
                if (p) begin
                    m_fs = 1; m_ph = 3; m_done = 1;
                end else if (remaining() == 0) begin
                    m_ph = 2; m_ms = 0;
                end else if (t) begin
                    m_ticks++;
                    if (remaining() == 0) begin m_ph = 2; m_ms = 0; end
                end
            end
            2: begin
                if (p) begin
                    m_ph = 3; m_done = 1;
                end else if (m) begin
                    m_ms++;
`ifdef ROUND_TIMEOUT_EN
                    if (m_ms == int'(TMO)) begin m_to = 1; m_ph = 3; m_done = 1; end
`endif
                end
            end
            default: if (g) begin
                m_ph = 1; m_ticks = 0; m_ms = 0; m_fs = 0; m_to = 0;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_count();
        return (m_ph == 0) ? 32'(INIT) : 32'(remaining());
    endfunction

    function automatic logic [31:0] exp_react();
        if (m_ph == 0) return 32'd0;
        if (m_fs || m_to || m_ms > 65535) return 32'h0000_FFFF;
        return 32'(m_ms);
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_state", 32'(bus.state), 32'(m_ph));
            check("cyc_count", 32'(bus.count), exp_count());
            check("cyc_start", 32'(bus.start), 32'(m_ph == 2));
            check("cyc_react", 32'(bus.react_time), exp_react());
            check("cyc_false_start", 32'(bus.false_start), 32'(m_fs));
            check("cyc_done", 32'(bus.done), 32'(m_done));
        end
    end

    task automatic cycle(input bit g, input bit t, input bit m, input bit p);
        @(negedge clock);
        #1;
        bus.go = g; bus.tick = t; bus.ms_tick = m; bus.press = p;
        @(posedge clock);
        model_step(g, t, m, p);
        #1;
        bus.go = 0; bus.tick = 0; bus.ms_tick = 0; bus.press = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_count"}, 32'(bus.count), 32'd5);
        check({tag, "_start"}, 32'(bus.start), 32'd0);
        check({tag, "_react"}, 32'(bus.react_time), 32'd0);
        check({tag, "_false_start"}, 32'(bus.false_start), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic run_countdown();
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.go = 0; bus.tick = 0; bus.ms_tick = 0; bus.press = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("por");
        @(negedge clock);
        #1;
        reset = 1'b1;
        cmp_en = 1'b1;

        // Countdown 5..0 with ignored go/ms_tick mixed in.
        cycle(1, 0, 0, 0);
        check("go_state", 32'(bus.state), 32'd1);
        check("go_count", 32'(bus.count), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) cycle(1, 0, 1, 0);
            cycle(0, 1, 0, 0);
            check("cd_count", 32'(bus.count), 32'(5 - i));
        end
        check("play_state", 32'(bus.state), 32'd2);
        check("play_start", 32'(bus.start), 32'd1);

        // 37 ms_ticks, then press together with an ms_tick (no increment).
        for (int i = 1; i <= 37; i++) begin
            if (i == 20) cycle(1, 1, 0, 0);
            cycle(0, (i % 7 == 0), 1, 0);
        end
        cycle(0, 0, 1, 1);
        check("hit_state", 32'(bus.state), 32'd3);
        check("hit_react", 32'(bus.react_time), 32'd37);
        check("hit_false_start", 32'(bus.false_start), 32'd0);
        check("hit_done", 32'(bus.done), 32'd1);
        check("hit_start", 32'(bus.start), 32'd0);
        cycle(0, 0, 0, 0);
        check("hit_done_drop", 32'(bus.done), 32'd0);
        cycle(0, 1, 1, 1);
        check("result_hold_react", 32'(bus.react_time), 32'd37);
        check("result_hold_state", 32'(bus.state), 32'd3);

        // go with simultaneous press from RESULT.
        cycle(1, 0, 0, 1);
        check("rego_state", 32'(bus.state), 32'd1);
        check("rego_count", 32'(bus.count), 32'd5);
        check("rego_false_start", 32'(bus.false_start), 32'd0);
        check("rego_react", 32'(bus.react_time), 32'd0);
        cycle(0, 0, 0, 0);
        check("rego_press_ignored", 32'(bus.state), 32'd1);

        // False start after the 2nd tick.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        check("fs_state", 32'(bus.state), 32'd3);
        check("fs_flag", 32'(bus.false_start), 32'd1);
        check("fs_react", 32'(bus.react_time), 32'hFFFF);
        check("fs_count", 32'(bus.count), 32'd3);
        check("fs_done", 32'(bus.done), 32'd1);

        // Press coincident with tick: press wins, count holds.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        check("fs_tick_count", 32'(bus.count), 32'd4);
        check("fs_tick_state", 32'(bus.state), 32'd3);

        // Asynchronous reset mid-PLAY at react_time 12.
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) cycle(0, 0, 1, 0);
        check("pre_reset_react", 32'(bus.react_time), 32'd12);
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_rst");
        @(negedge clock);
        #1;
        reset = 1'b1;

        run_countdown();
        check("play2_state", 32'(bus.state), 32'd2);
`ifdef ROUND_TIMEOUT_EN
        for (int i = 1; i <= 10; i++) cycle(0, 0, 1, 0);
        check("tmo_state", 32'(bus.state), 32'd3);
        check("tmo_react", 32'(bus.react_time), 32'hFFFF);
        check("tmo_false_start", 32'(bus.false_start), 32'd0);
        check("tmo_done", 32'(bus.done), 32'd1);
`else
        for (int i = 1; i <= 65540; i++) cycle(0, 0, 1, 0);
        check("sat_state", 32'(bus.state), 32'd2);
        check("sat_react", 32'(bus.react_time), 32'hFFFF);
        check("sat_start", 32'(bus.start), 32'd1);
`endif
        cycle(0, 0, 0, 0);
        @(negedge clock);
        #2;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
